ppg_multich_calib_ctrl: RTL and testbench

Parametrised successor of the PPG front-end controller. It calibrates N_CH LED channels in sequence. For each channel it runs a successive-approximation (SAR) search of the DC-compensation DAC that centres the ADC code at MID_CODE, then a PGA-gain ramp up to one step below clipping. After calibration it time-multiplexes the channels with their stored settings and emits per-channel ADC samples plus a frame strobe for the downstream filters. It sits between the analog front-end (LED driver, DC-comp DAC, PGA, ADC) and the FIR filter bank.

---
 rtl/ppg_multich_calib_ctrl.sv | 253 +++++++++++++++++++++++++
 tb/tb_ppg_multich_calib_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/ppg_multich_calib_ctrl.sv
// PPG front-end controller: per-channel SAR DC-comp search and PGA gain ramp, then time-multiplexed sampling.
// Define OVERSAMPLE_AVG_EN to average the last four cycles of each RUN slot instead of taking a single capture.
module ppg_multich_calib_ctrl #(
  parameter int N_CH      = 2,
  parameter int ADC_W     = 8,
  parameter int DC_W      = 7,
  parameter int GAIN_W    = 4,
  parameter int MID_CODE  = 127,
  parameter int CLIP_CODE = 250,
  parameter int SETTLE    = 16,
  parameter int SLOT_LEN  = 10
) (
  input  logic                                      CLK,
  input  logic                                      rst,
  input  logic                                      start,
  input  logic [ADC_W-1:0]                          adc_data,
  output logic                                      busy,
  output logic                                      done,
  output logic [N_CH-1:0]                           cal_clip,
  output logic [N_CH-1:0]                           led_en,
  output logic [DC_W-1:0]                           dc_comp,
  output logic [GAIN_W-1:0]                         pga_gain,
  output logic                                      sample_valid,
  output logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] sample_ch,
  output logic [ADC_W-1:0]                          sample_data,
  output logic                                      frame_strobe
);

  localparam int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int BI_W    = (DC_W > 1) ? $clog2(DC_W) : 1;
  localparam int CNT_MAX = (SETTLE > SLOT_LEN) ? SETTLE : SLOT_LEN;
  localparam int CNT_W   = $clog2(CNT_MAX);

  typedef enum logic [2:0] {IDLE, DC_SAR, GAIN_STEP, STORE, RUN} state_t;

  state_t             state, state_n;
  logic [CH_W-1:0]    ch, ch_n, ch_nx;
  logic [BI_W-1:0]    bidx, bidx_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [ADC_W-1:0]   peak, peak_n, peak_eff;
  logic [GAIN_W-1:0]  fgain, fgain_n;
  logic [DC_W-1:0]    dc_store [N_CH];
  logic [DC_W-1:0]    dc_store_n [N_CH];
  logic [GAIN_W-1:0]  gain_store [N_CH];
  logic [GAIN_W-1:0]  gain_store_n [N_CH];
  logic [DC_W-1:0]    bit_mask, kept;
  logic               launch;

  logic               busy_n, done_n, sample_valid_n, frame_strobe_n;
  logic [N_CH-1:0]    cal_clip_n, led_en_n;
  logic [DC_W-1:0]    dc_comp_n;
  logic [GAIN_W-1:0]  pga_gain_n;
  logic [CH_W-1:0]    sample_ch_n;
  logic [ADC_W-1:0]   sample_data_n;

`ifdef OVERSAMPLE_AVG_EN
  localparam int ACC_W = ADC_W + 2;
  logic [ACC_W-1:0]   acc, acc_n, acc_sum;
`endif

  always_comb begin
    state_n        = state;
    ch_n           = ch;
    bidx_n         = bidx;
    cnt_n          = cnt;
    peak_n         = peak;
    fgain_n        = fgain;
    dc_store_n     = dc_store;
    gain_store_n   = gain_store;
    busy_n         = busy;
    done_n         = 1'b0;
    cal_clip_n     = cal_clip;
    led_en_n       = led_en;
    dc_comp_n      = dc_comp;
    pga_gain_n     = pga_gain;
    sample_valid_n = 1'b0;
    sample_ch_n    = sample_ch;
    sample_data_n  = sample_data;
    frame_strobe_n = 1'b0;

    ch_nx    = (ch == CH_W'(N_CH - 1)) ? '0 : ch + CH_W'(1);
    peak_eff = (adc_data > peak) ? adc_data : peak;
    bit_mask = DC_W'(1) << bidx;
    // A higher DAC code pulls the ADC code down, so a code above target keeps the trial bit.
    kept     = (adc_data > ADC_W'(MID_CODE)) ? dc_comp : (dc_comp & ~bit_mask);
    launch   = start && (state == IDLE || state == RUN);
`ifdef OVERSAMPLE_AVG_EN
    acc_n   = acc;
    acc_sum = acc + ACC_W'(adc_data);
`endif

    case (state)
      IDLE: ;

      DC_SAR: begin
        if (cnt == CNT_W'(SETTLE - 1)) begin
          cnt_n = '0;
          if (bidx == '0) begin
            dc_comp_n  = kept;
            pga_gain_n = '0;
            peak_n     = '0;
            state_n    = GAIN_STEP;
          end else begin
            bidx_n    = bidx - BI_W'(1);
            dc_comp_n = kept | (bit_mask >> 1);
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end

      GAIN_STEP: begin
        peak_n = peak_eff;
        cnt_n  = cnt + CNT_W'(1);
        if (cnt == CNT_W'(SETTLE - 1)) begin
          cnt_n  = '0;
          peak_n = '0;
          if (peak_eff >= ADC_W'(CLIP_CODE)) begin
            fgain_n    = (pga_gain == '0) ? '0 : pga_gain - GAIN_W'(1);
            pga_gain_n = (pga_gain == '0) ? '0 : pga_gain - GAIN_W'(1);
            if (pga_gain == '0)
              cal_clip_n[ch] = 1'b1;
            state_n = STORE;
          end else if (pga_gain == '1) begin
            fgain_n = pga_gain;
            state_n = STORE;
          end else begin
            pga_gain_n = pga_gain + GAIN_W'(1);
          end
        end
      end

      STORE: begin
        dc_store_n[ch]   = dc_comp;
        gain_store_n[ch] = fgain;
        cnt_n            = '0;
        if (ch != CH_W'(N_CH - 1)) begin
          // The SAR result restarts from zero, so the first trial code goes straight out.
          ch_n       = ch + CH_W'(1);
          led_en_n   = led_en << 1;
          bidx_n     = BI_W'(DC_W - 1);
          dc_comp_n  = DC_W'(1) << (DC_W - 1);
          pga_gain_n = '0;
          peak_n     = '0;
          state_n    = DC_SAR;
        end else begin
          done_n     = 1'b1;
          busy_n     = 1'b0;
          ch_n       = '0;
          led_en_n   = N_CH'(1);
          dc_comp_n  = dc_store_n[0];
          pga_gain_n = gain_store_n[0];
          state_n    = RUN;
        end
      end

      RUN: begin
`ifdef OVERSAMPLE_AVG_EN
        if (cnt == CNT_W'(SLOT_LEN - 4))
          acc_n = ACC_W'(adc_data);
        else if (cnt > CNT_W'(SLOT_LEN - 4))
          acc_n = acc_sum;
`endif
        if (cnt == CNT_W'(SLOT_LEN - 1)) begin
`ifdef OVERSAMPLE_AVG_EN
          sample_data_n = acc_sum[ACC_W-1:2];
`else
          sample_data_n = adc_data;
`endif
          sample_ch_n    = ch;
          sample_valid_n = 1'b1;
          frame_strobe_n = (ch == CH_W'(N_CH - 1));
          ch_n           = ch_nx;
          led_en_n       = N_CH'(1) << ch_nx;
          dc_comp_n      = dc_store[ch_nx];
          pga_gain_n     = gain_store[ch_nx];
          cnt_n          = '0;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end

      default: state_n = IDLE;
    endcase

    // Launch overrides RUN, so a sample due in the same cycle is dropped.
    if (launch) begin
      state_n        = DC_SAR;
      ch_n           = '0;
      bidx_n         = BI_W'(DC_W - 1);
      cnt_n          = '0;
      peak_n         = '0;
      busy_n         = 1'b1;
      cal_clip_n     = '0;
      led_en_n       = N_CH'(1);
      dc_comp_n      = DC_W'(1) << (DC_W - 1);
      pga_gain_n     = '0;
      sample_valid_n = 1'b0;
      frame_strobe_n = 1'b0;
      sample_ch_n    = sample_ch;
      sample_data_n  = sample_data;
    end
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      state        <= IDLE;
      ch           <= '0;
      bidx         <= '0;
      cnt          <= '0;
      peak         <= '0;
      fgain        <= '0;
      dc_store     <= '{default: '0};
      gain_store   <= '{default: '0};
      busy         <= 1'b0;
      done         <= 1'b0;
      cal_clip     <= '0;
      led_en       <= '0;
      dc_comp      <= '0;
      pga_gain     <= '0;
      sample_valid <= 1'b0;
      sample_ch    <= '0;
      sample_data  <= '0;
      frame_strobe <= 1'b0;
`ifdef OVERSAMPLE_AVG_EN
      acc          <= '0;
`endif
    end else begin
      state        <= state_n;
      ch           <= ch_n;
      bidx         <= bidx_n;
      cnt          <= cnt_n;
      peak         <= peak_n;
      fgain        <= fgain_n;
      dc_store     <= dc_store_n;
      gain_store   <= gain_store_n;
      busy         <= busy_n;
      done         <= done_n;
      cal_clip     <= cal_clip_n;
      led_en       <= led_en_n;
      dc_comp      <= dc_comp_n;
      pga_gain     <= pga_gain_n;
      sample_valid <= sample_valid_n;
      sample_ch    <= sample_ch_n;
      sample_data  <= sample_data_n;
      frame_strobe <= frame_strobe_n;
`ifdef OVERSAMPLE_AVG_EN
      acc          <= acc_n;
`endif
    end
  end

endmodule

// File: tb/tb_ppg_multich_calib_ctrl.sv
// Bench for ppg_multich_calib_ctrl: a 2-channel unit for calibration flow, a 3-channel unit for RUN sampling.
module tb_ppg_multich_calib_ctrl;

  localparam int SLOT = 10;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic       rst, start2, start3;
  logic [7:0] adc2, adc3;

  logic       busy2, done2, sv2, fs2;
  logic [1:0] clip2, led2;
  logic [6:0] dc2;
  logic [3:0] g2;
  logic [0:0] sch2;
  logic [7:0] sd2;

  logic       busy3, done3, sv3, fs3;
  logic [2:0] clip3, led3;
  logic [6:0] dc3;
  logic [3:0] g3;
  logic [1:0] sch3;
  logic [7:0] sd3;

  ppg_multich_calib_ctrl u_dut2 (
    .CLK(CLK), .rst(rst), .start(start2), .adc_data(adc2),
    .busy(busy2), .done(done2), .cal_clip(clip2), .led_en(led2),
    .dc_comp(dc2), .pga_gain(g2), .sample_valid(sv2), .sample_ch(sch2),
    .sample_data(sd2), .frame_strobe(fs2)
  );

  ppg_multich_calib_ctrl #(.N_CH(3), .SLOT_LEN(SLOT)) u_dut3 (
    .CLK(CLK), .rst(rst), .start(start3), .adc_data(adc3),
    .busy(busy3), .done(done3), .cal_clip(clip3), .led_en(led3),
    .dc_comp(dc3), .pga_gain(g3), .sample_valid(sv3), .sample_ch(sch3),
    .sample_data(sd3), .frame_strobe(fs3)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Analog front-end stand-in: higher DAC code lowers the ADC code, gain raises it.
  function automatic logic [7:0] lin(input logic [6:0] dc, input logic [3:0] g);
    int v;
    v = 254 - 2 * int'(dc) + 8 * int'(g);
    if (v < 0) v = 0;
    if (v > 255) v = 255;
    return 8'(v);
  endfunction

  typedef struct packed {
    logic [1:0] ch;
    logic [7:0] data;
    logic       fs;
  } exp_t;

  exp_t q[$];
  int   mode2 = 0;
  logic arm3 = 1'b0, run3 = 1'b0;
  int   mcnt, mch, slot_no, popped = 0;
  logic [9:0] macc;

  task automatic step();
    logic [7:0] v;
    logic [7:0] ed;
    logic [7:0] forced [4];
    exp_t e;
    forced = '{8'd10, 8'd20, 8'd30, 8'd41};
    @(negedge CLK);
    if (run3) begin
      if (sv3) begin
        if (q.size() == 0) begin
          check("sv3_unexpected", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          check("sample_ch", 32'(sch3), 32'(e.ch));
          check("sample_data", 32'(sd3), 32'(e.data));
          check("frame_strobe", 32'(fs3), 32'(e.fs));
          popped++;
        end
      end else begin
        check("frame_quiet", 32'(fs3), 32'd0);
      end
      check("led_en3", 32'(led3), 32'(1 << mch));
      check("run_dc3", 32'(dc3), 32'd63);
    end
    if (arm3 && !run3 && done3) begin
      run3 = 1'b1; mch = 0; mcnt = 0; slot_no = 0; macc = '0;
    end
    adc2 = (mode2 == 1 && led2[1]) ? 8'd255 : lin(dc2, g2);
    if (run3) begin
      if (slot_no == 0 && mcnt >= SLOT - 4) v = forced[mcnt - (SLOT - 4)];
      else v = 8'($urandom_range(0, 255));
      adc3 = v;
      if (mcnt == SLOT - 4) macc = 10'(v);
      else if (mcnt > SLOT - 4) macc = macc + 10'(v);
      if (mcnt == SLOT - 1) begin
`ifdef OVERSAMPLE_AVG_EN
        ed = macc[9:2];
`else
        ed = v;
`endif
        q.push_back('{ch: 2'(mch), data: ed, fs: (mch == 2)});
        mch = (mch + 1) % 3;
        mcnt = 0;
        slot_no++;
      end else begin
        mcnt++;
      end
    end else begin
      adc3 = lin(dc3, g3);
    end
  endtask

  int n;

  initial begin
    rst = 1'b1; start2 = 1'b0; start3 = 1'b0; adc2 = '0; adc3 = '0;
    repeat (3) step();
    rst = 1'b0;
    step();
    check("rst_busy", 32'(busy2), 32'd0);
    check("rst_led", 32'(led2), 32'd0);
    check("rst_dc_gain", 32'({dc2, g2}), 32'd0);

    // Reset in the middle of the first SAR trial
    start2 = 1'b1; step(); start2 = 1'b0;
    check("launch_busy", 32'(busy2), 32'd1);
    check("launch_led", 32'(led2), 32'd1);
    check("launch_dc", 32'(dc2), 32'h40);
    repeat (4) step();
    check("trial0_dc", 32'(dc2), 32'h40);
    rst = 1'b1; step();
    check("midrst_busy", 32'(busy2), 32'd0);
    check("midrst_outs", 32'({led2, dc2, g2, clip2, done2, sv2, fs2}), 32'd0);
    repeat (2) step();
    rst = 1'b0;
    repeat (5) step();
    check("idle_after_rst", 32'({busy2, led2, dc2}), 32'd0);

    // Full 2-channel calibration, start during calibration must be ignored
    start2 = 1'b1; step(); start2 = 1'b0;
    n = 0;
    while (done2 !== 1'b1 && n < 2000) begin
      if (n == 49) start2 = 1'b1;
      step(); n++;
      if (n == 50) begin
        start2 = 1'b0;
        check("start_ignored_dc", 32'(dc2), 32'd56);
        check("start_ignored_busy", 32'(busy2), 32'd1);
      end
    end
    check("done_cycles", 32'(n), 32'(2 * (7 * 16 + 16 * 16 + 1)));
    check("done_busy", 32'(busy2), 32'd0);
    check("done_clip", 32'(clip2), 32'd0);
    check("run_ch0_dc", 32'(dc2), 32'd63);
    check("run_ch0_gain", 32'(g2), 32'd15);
    while (n < 757) begin
      step(); n++;
      if (n == 739) check("done_pulse", 32'(done2), 32'd0);
      if (n == 748) begin
        check("run2_valid", 32'(sv2), 32'd1);
        check("run2_ch", 32'(sch2), 32'd0);
        check("run2_data", 32'(sd2), 32'd248);
        check("run2_led", 32'(led2), 32'd2);
      end
    end

    // Restart from RUN on a sampling cycle; ch1 now saturates
    start2 = 1'b1; mode2 = 1; step(); start2 = 1'b0;
    check("restart_drop", 32'(sv2), 32'd0);
    check("restart_busy", 32'(busy2), 32'd1);
    check("restart_led_dc", 32'({led2, dc2, g2}), 32'({2'd1, 7'h40, 4'd0}));
    n = 0;
    while (done2 !== 1'b1 && n < 2000) begin
      step(); n++;
    end
    check("clip_done_cycles", 32'(n), 32'((7 * 16 + 16 * 16 + 1) + (7 * 16 + 16 + 1)));
    check("cal_clip", 32'(clip2), 32'd2);
    check("clip_ch0_dc_gain", 32'({dc2, g2}), 32'({7'd63, 4'd15}));
    repeat (SLOT) step();
    check("clip_ch1_led", 32'(led2), 32'd2);
    check("clip_ch1_dc", 32'(dc2), 32'd127);
    check("clip_ch1_gain", 32'(g2), 32'd0);

    // 3-channel RUN scoreboard
    start3 = 1'b1; step(); start3 = 1'b0;
    arm3 = 1'b1;
    for (int i = 0; i < 1600 && popped < 7; i++) step();
    check("samples3", 32'(popped), 32'd7);
    check("clip3", 32'(clip3), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
